vector_dot_product_engine: RTL

//  Streaming, folded signed fixed-point dot product for neuron evaluation.

---
 rtl/vector_engine_pkg.sv | 39 +++
 rtl/dot_product_lane_array.sv | 34 +++
 rtl/vector_dot_product_engine.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vector_engine_pkg.sv
// Shared types, defaults and the rescale/saturate helper for the vector dot product engine.
package vector_engine_pkg;

    localparam int DEFAULT_FIXED_POINT_WIDTH    = 16;
    localparam int DEFAULT_FIXED_POINT_POSITION = 10;

    // Rescale works on a fixed wide container so one function serves every parameterisation.
    localparam int RESCALE_W     = 64;
    localparam int RESCALE_VAL_W = 32;

    typedef logic signed [RESCALE_W-1:0] rescale_t;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        HOLD
    } engine_state_t;

    // Returns {saturated, value}; value occupies the low 'width' bits of the RESCALE_VAL_W field.
    function automatic logic [RESCALE_VAL_W:0] sat_rescale(input rescale_t acc, input int frac,
                                                           input int width);
        rescale_t shifted;
        rescale_t max_v;
        rescale_t min_v;
        logic [RESCALE_VAL_W:0] r;
        shifted = acc >>> frac;
        max_v   = (rescale_t'(1) <<< (width - 1)) - rescale_t'(1);
        min_v   = -(rescale_t'(1) <<< (width - 1));
        if (shifted > max_v) begin
            r = {1'b1, max_v[RESCALE_VAL_W-1:0]};
        end else if (shifted < min_v) begin
            r = {1'b1, min_v[RESCALE_VAL_W-1:0]};
        end else begin
            r = {1'b0, shifted[RESCALE_VAL_W-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_product_lane_array.sv
// LANES registered full-precision signed multipliers followed by a combinational lane-sum tree.
module dot_product_lane_array #(
    parameter int LANES  = 8,
    parameter int DATA_W = 16,
    parameter int SUM_W  = 2 * DATA_W + $clog2(LANES) + 1
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [LANES-1:0][DATA_W-1:0]   vec_a,
    input  logic [LANES-1:0][DATA_W-1:0]   vec_b,
    output logic signed [SUM_W-1:0]        lane_sum
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_p1 [LANES];

    // P1: lane products, captured only on accepted beats
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                prod_p1[i] <= PROD_W'($signed(vec_a[i])) * PROD_W'($signed(vec_b[i]));
            end
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SUM_W'(prod_p1[i]);
        end
    end

endmodule

// File: rtl/vector_dot_product_engine.sv
// Streaming folded signed fixed-point dot product with one vector in flight at a time.
// Optional ReLU output clamp when DOT_PRODUCT_RELU_EN is defined.
module vector_dot_product_engine
    import vector_engine_pkg::*;
#(
    parameter int VECTOR_LENGTH        = 64,
    parameter int LANES                = 8,
    parameter int FIXED_POINT_WIDTH    = DEFAULT_FIXED_POINT_WIDTH,
    parameter int FIXED_POINT_POSITION = DEFAULT_FIXED_POINT_POSITION
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic [LANES-1:0][FIXED_POINT_WIDTH-1:0]     vec_a_in,
    input  logic [LANES-1:0][FIXED_POINT_WIDTH-1:0]     vec_b_in,
    input  logic                                        in_valid_in,
    output logic                                        in_ready_out,
    output logic [FIXED_POINT_WIDTH-1:0]                result_out,
    output logic                                        saturated_out,
    output logic                                        out_valid_out,
    input  logic                                        out_ready_in
);

    localparam int W          = FIXED_POINT_WIDTH;
    localparam int NUM_CHUNKS = VECTOR_LENGTH / LANES;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int SUM_W      = 2 * W + $clog2(LANES) + 1;
    localparam int ACC_W      = 2 * W + $clog2(VECTOR_LENGTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if (VECTOR_LENGTH % LANES != 0) begin : g_bad_length
        $error("VECTOR_LENGTH must be a multiple of LANES");
    end
    if (ACC_W >= RESCALE_W || W >= RESCALE_VAL_W) begin : g_bad_width
        $error("FIXED_POINT_WIDTH too large for the rescale container");
    end

    engine_state_t            state;
    logic [CNT_W-1:0]         chunk_cnt;
    logic                     drain_cnt;
    logic                     vld_p1, first_p1, last_p1;
    logic                     vld_p2, last_p2;
    logic signed [ACC_W-1:0]  acc_p2;
    logic signed [SUM_W-1:0]  lane_sum;
    logic [RESCALE_VAL_W:0]   rescaled;
    logic [W-1:0]             res_next;
    logic                     sat_next;
    logic                     unused_rescale_hi;

    wire accept     = in_valid_in && in_ready_out;
    wire chunk_last = (chunk_cnt == LAST_CHUNK);

    dot_product_lane_array #(
        .LANES  (LANES),
        .DATA_W (W),
        .SUM_W  (SUM_W)
    ) u_lanes (
        .clk      (clk_in),
        .en       (accept),
        .vec_a    (vec_a_in),
        .vec_b    (vec_b_in),
        .lane_sum (lane_sum)
    );

    assign rescaled = sat_rescale({{(RESCALE_W - ACC_W){acc_p2[ACC_W-1]}}, acc_p2},
                                  FIXED_POINT_POSITION, W);
    assign unused_rescale_hi = ^rescaled[RESCALE_VAL_W-1:W];

    always_comb begin
        res_next = rescaled[W-1:0];
        sat_next = rescaled[RESCALE_VAL_W];
`ifdef DOT_PRODUCT_RELU_EN
        // Floor shift preserves sign, so a negative accumulator means a negative rescaled sum.
        if (acc_p2[ACC_W-1]) begin
            res_next = '0;
            sat_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= ACCUM;
            chunk_cnt     <= '0;
            drain_cnt     <= 1'b0;
            vld_p1        <= 1'b0;
            first_p1      <= 1'b0;
            last_p1       <= 1'b0;
            vld_p2        <= 1'b0;
            last_p2       <= 1'b0;
            acc_p2        <= '0;
            in_ready_out  <= 1'b1;
            out_valid_out <= 1'b0;
            result_out    <= '0;
            saturated_out <= 1'b0;
        end else begin
            // P1 control alongside the registered lane products
            vld_p1   <= accept;
            first_p1 <= accept && (chunk_cnt == '0);
            last_p1  <= accept && chunk_last;
            if (accept) begin
                chunk_cnt <= chunk_last ? '0 : chunk_cnt + 1'b1;
            end

            // P2: accumulate, restarting from zero on the first chunk of a vector
            vld_p2  <= vld_p1;
            last_p2 <= vld_p1 && last_p1;
            if (vld_p1) begin
                acc_p2 <= (first_p1 ? '0 : acc_p2) + ACC_W'(lane_sum);
            end

            // P3: rescale and saturate into the output register
            if (last_p2) begin
                result_out    <= res_next;
                saturated_out <= sat_next;
                out_valid_out <= 1'b1;
            end

            case (state)
                ACCUM: begin
                    if (accept && chunk_last) begin
                        state        <= DRAIN;
                        in_ready_out <= 1'b0;
                        drain_cnt    <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready_in && out_valid_out) begin
                        state         <= ACCUM;
                        out_valid_out <= 1'b0;
                        in_ready_out  <= 1'b1;
                    end
                end
                default: begin
                    state        <= ACCUM;
                    in_ready_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
